// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone B4 RAM slave with wait states, registered-feedback bursts, console/pass MMIO
module wb_ram_burst #(
  parameter int          DW           = 32,
  parameter int          DEPTH_BYTES  = 131072,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [31:0]     wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            console_valid,
  output logic [7:0]      console_data,
  output logic            tests_passed
);

  localparam int          NB        = DW / 8;
  localparam int          SH        = $clog2(NB);
  localparam int          WORDS     = DEPTH_BYTES / NB;
  localparam int          AW        = $clog2(WORDS);
  localparam logic [2:0]  WS_LOAD   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
  localparam logic [32:0] DEPTH_LIM = 33'(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [2:0]  cti_q, cti_d;
  logic [1:0]  bte_q, bte_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        console_valid_q, tests_passed_q;
  logic [7:0]  console_data_q;

  logic [DW-1:0] mem [0:WORDS-1];
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] rd_idx;

  logic        valid, term, ack, err, in_range, is_console, is_pass, last_beat, wr_mem;
  logic [31:0] idx_q, idx_nxt, wrap_mask;

  assign valid      = wb_cyc_i & wb_stb_i;
  assign in_range   = {1'b0, adr_q} < DEPTH_LIM;
  assign is_console = (adr_q == CONSOLE_ADDR);
  assign is_pass    = (adr_q == PASS_ADDR);
  assign term       = valid && (state_q == S_ACK || state_q == S_BURST);
  assign ack        = term & (in_range | is_console | is_pass);
  assign err        = term & ~(in_range | is_console | is_pass);
  assign wr_mem     = ack & wb_we_i & in_range;
  // 000 arriving mid-burst is an early end, same as 111
  assign last_beat  = (wb_cti_i == 3'b111) || (wb_cti_i == 3'b000);

  // Burst index step: wrap modes keep the upper index bits fixed
  assign idx_q = adr_q >> SH;
  always_comb begin
    wrap_mask = 32'hFFFF_FFFF;
    case (bte_q)
      2'b01:   wrap_mask = 32'h0000_0003;
      2'b10:   wrap_mask = 32'h0000_0007;
      2'b11:   wrap_mask = 32'h0000_000F;
      default: wrap_mask = 32'hFFFF_FFFF;
    endcase
    idx_nxt = (idx_q & ~wrap_mask) | ((idx_q + 32'd1) & wrap_mask);
  end

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (WAIT_STATES == 0) state_d = (wb_cti_i == 3'b010) ? S_BURST : S_ACK;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i)        state_d = S_IDLE;
        else if (cnt_q == 0)  state_d = (cti_q == 3'b010) ? S_BURST : S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      S_BURST: begin
        if (!wb_cyc_i)                  state_d = S_IDLE;
        else if (wb_stb_i && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs; read data is forced to zero outside in-range terminated beats
  always_comb begin
    wb_ack_o = ack;
    wb_err_o = err;
    wb_dat_o = (term && in_range) ? rdata_q : '0;
  end

  // Request capture, wait countdown and burst address advance
  always_comb begin
    adr_d = adr_q;
    cti_d = cti_q;
    bte_d = bte_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE && valid) begin
      adr_d = wb_adr_i;
      cti_d = wb_cti_i;
      bte_d = wb_bte_i;
      cnt_d = WS_LOAD;
    end else if (state_q == S_WAIT && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end else if (state_q == S_BURST && term) begin
      adr_d = idx_nxt << SH;
    end
  end

  // Datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr_q <= '0;
      cti_q <= '0;
      bte_q <= '0;
      cnt_q <= '0;
    end else begin
      adr_q <= adr_d;
      cti_q <= cti_d;
      bte_q <= bte_d;
      cnt_q <= cnt_d;
    end
  end

  // Read index for next cycle: prefetch the following beat whenever one terminates
  always_comb begin
    rd_idx = idx_q[AW-1:0];
    if (state_q == S_IDLE)              rd_idx = wb_adr_i[SH +: AW];
    else if (state_q == S_BURST && term) rd_idx = idx_nxt[AW-1:0];
  end

  // Synchronous RAM: byte-lane writes on acked beats, registered read
  always_ff @(posedge wb_clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_mem && wb_sel_i[b]) mem[idx_q[AW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
    end
    rdata_q <= mem[rd_idx];
  end

  // Console byte pulse and sticky pass flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      tests_passed_q  <= 1'b0;
    end else begin
      console_valid_q <= ack & wb_we_i & is_console & wb_sel_i[0];
      if (ack && wb_we_i && is_console && wb_sel_i[0]) console_data_q <= wb_dat_i[7:0];
      if (ack && wb_we_i && is_pass && (&wb_sel_i) && wb_dat_i[31:0] == PASS_VALUE)
        tests_passed_q <= 1'b1;
    end
  end

  assign console_valid = console_valid_q;
  assign console_data  = console_data_q;
  assign tests_passed  = tests_passed_q;

endmodule
